multiplier_appr_half: RTL and testbench
=======================================

MULTIPLIER_APPR_HALF -- requirements
Module: multiplier_appr_half

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 A  input  16  signed two's-complement multiplicand.
REQ-005 B  input  16  signed two's-complement multiplier.
REQ-006 out  output  32  signed two's-complement approximate product, registered.
REQ-007 The block SHALL have no parameters; widths are fixed at 16x16 -> 32.

Function
REQ-008 The block SHALL recode B as radix-4 Booth, giving 8 digits d_i for i = 0..7.
  - Digit source bits: {B[2i+1], B[2i], B[2i-1]}, with B[-1] = 0.
  - Digit map: 000/111 -> 0; 001/010 -> +1; 011 -> +2; 100 -> -2; 101/110 -> -1.
REQ-009 Each partial product SHALL be pp_i = (d_i * A) sign-extended to 32 bits, shifted left by 2i, taken modulo 2^32.
  - Negative digits use the two's complement.
  - Bits below position 2i are zero.
REQ-010 The exact sum P = (sum over i of pp_i) mod 2^32 SHALL equal A*B; all 16x16 signed products fit in 32 bits, including -32768 * -32768 = 0x40000000.
REQ-011 out[31:16] SHALL equal P[31:16] exactly.
  - All carries generated in columns 0..15 propagate into the upper half.
REQ-012 out[15:0] SHALL equal the bitwise OR of pp_i[15:0] over i = 0..7.
  - This is the approximate lower-half compression; no carries inside the lower half.
REQ-013 The error out - A*B SHALL be confined to bits [15:0], so |error| < 2^16.
  - Error is zero whenever at most one pp_i has nonzero bits in [15:0], or all pp_i[15:0] are bitwise disjoint.
REQ-014 The carry-out of column 15 SHALL be computed exactly.
  - Example structure: 4:2 compressor tree over 8 partial products plus a final adder.
  - Upper half is exact; lower-half OR values never feed the upper half.
REQ-015 Latency SHALL be 1 cycle.
  - A and B sampled on rising edge k appear on out after edge k.
  - New operands are accepted every cycle; no handshake, no stall.
REQ-016 out SHALL hold its value between clock edges; A and B are combinational only up to the output register.
REQ-017 Result bit 31 SHALL be treated as the sign bit.
  - Downstream fixed-point users may arithmetic-shift out; the block itself performs no shift or rounding.

Reset
REQ-018 While rst_n = 0, out SHALL be 32'h0000_0000, asynchronously and independently of clk.
REQ-019 After rst_n deasserts, the first rising edge SHALL load the product of the A and B present at that edge.
REQ-020 Reset asserted mid-stream SHALL discard the in-flight result; no pending value appears after release.

Verification
REQ-021 A=0, B=0x1234 -> out=0x00000000 one cycle later.
REQ-022 A=1, B=1 -> out=1; A=0xFFFF (-1), B=1 -> out=0xFFFFFFFF (-1); both exact.
REQ-023 A=3, B=3 -> pp0=0xFFFFFFFD, pp1=0x0000000C -> out=0x0000FFFD (65533) vs exact 9.
  - Confirms the lower-half OR and the exact upper half.
REQ-024 A=0x8000, B=0x8000 -> out=0x40000000.
  - Only d7 = -2 is nonzero; result is exact.
REQ-025 Back-to-back random operands, one pair per cycle -> each out matches the REQ-011/REQ-012 model one cycle later.
  - out[31:16] always equals (A*B)[31:16].
REQ-026 Drive rst_n low between edges while a result is pending -> out=0 immediately.
  - out stays 0 until the first edge after release, then shows the product of the operands present at that edge.

Source files
------------

// File: rtl/multiplier_appr_half_if.sv
// Operand/result bundle for the approximate half-exact 16x16 signed multiplier.
// The master drives the operands and sees the registered product.
interface multiplier_appr_half_if;
   logic [15:0] A;
   logic [15:0] B;
   logic [31:0] out;

   modport master (output A, output B, input out);
   modport slave  (input A, input B, output out);
endinterface

// File: rtl/multiplier_appr_half.sv
// Approximate 16x16 signed multiplier, radix-4 Booth recoded.
// Upper product half is exact (carries from the low columns included);
// the lower half is the bitwise OR of the partial products, with no carries.
// One-cycle latency, new operands every cycle.
module multiplier_appr_half (
   input  logic                 clk,
   input  logic                 rst_n,
   multiplier_appr_half_if.slave bus
);

   logic [31:0] a_ext;
   logic [16:0] b_pad;
   logic [31:0] pp [8];
   logic [31:0] sum_l1 [4];
   logic [31:0] sum_l2 [2];
   logic [31:0] sum_exact;
   logic [15:0] low_or;
   logic [31:0] out_reg;

   assign a_ext = {{16{bus.A[15]}}, bus.A};
   // B[-1] = 0 sits at index 0, so digit gi reads b_pad[2gi+2:2gi].
   assign b_pad = {bus.B, 1'b0};

   // One Booth digit and its partial product per generate slice.
   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_booth
         localparam int SH = 2 * gi;
         logic [2:0]  bits;
         logic        zero;
         logic        neg;
         logic        dbl;
         logic [31:0] mag;
         logic [31:0] sgn_mag;

         assign bits    = b_pad[SH+2:SH];
         assign zero    = (bits == 3'b000) || (bits == 3'b111);
         assign dbl     = (bits == 3'b011) || (bits == 3'b100);
         assign neg     = bits[2];
         assign mag     = dbl ? (a_ext << 1) : a_ext;
         assign sgn_mag = neg ? (~mag + 32'd1) : mag;
         assign pp[gi]  = zero ? 32'd0 : (sgn_mag << SH);
      end

      // First level of the exact adder tree: pairs of partial products.
      for (genvar gi = 0; gi < 4; gi++) begin : g_l1
         assign sum_l1[gi] = pp[2*gi] + pp[2*gi+1];
      end

      for (genvar gi = 0; gi < 2; gi++) begin : g_l2
         assign sum_l2[gi] = sum_l1[2*gi] + sum_l1[2*gi+1];
      end
   endgenerate

   // The full exact sum is kept so every low-column carry reaches bit 16.
   assign sum_exact = sum_l2[0] + sum_l2[1];

   // Carry-free lower half: OR the low 16 bits of all partial products.
   always_comb begin
      low_or = 16'd0;
      for (int i = 0; i < 8; i++) begin
         low_or = low_or | pp[i][15:0];
      end
   end

   // Output register; reset clears it immediately and drops any pending result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_reg <= 32'h0000_0000;
      end else begin
         out_reg <= {sum_exact[31:16], low_or};
      end
   end

   assign bus.out = out_reg;

endmodule

// File: tb/tb_multiplier_appr_half.sv
// Directed checks for the approximate half-exact Booth multiplier, plus a
// short back-to-back random run against an independent bit-level model.
module tb_multiplier_appr_half;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   multiplier_appr_half_if bus ();

   multiplier_appr_half dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish (got running, want finished)");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %08h want %08h", tag, got, exp);
      end else begin
         $display("ok   %s: %08h", tag, got);
      end
   endtask

   // Booth digit d = -2*b[2i+1] + b[2i] + b[2i-1]; upper half from the exact
   // sum, lower half from OR of the partial products.
   function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] bp;
      logic [31:0] p;
      logic [31:0] s;
      logic [31:0] lo;
      int          d;
      bp = {b, 1'b0};
      s  = 32'd0;
      lo = 32'd0;
      for (int i = 0; i < 8; i++) begin
         d  = -2 * int'(bp[2*i+2]) + int'(bp[2*i+1]) + int'(bp[2*i]);
         p  = 32'(d * int'($signed(a))) << (2 * i);
         s  = s + p;
         lo = lo | p;
      end
      return {s[31:16], lo[15:0]};
   endfunction

   task automatic apply(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] exp);
      @(negedge clk);
      bus.A = a;
      bus.B = b;
      @(posedge clk);
      #1;
      check(tag, bus.out, exp);
   endtask

   initial begin
      logic [15:0] ra;
      logic [15:0] rb;
      logic [31:0] exact;
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      bus.A  = 16'h1234;
      bus.B  = 16'h5678;

      repeat (2) @(posedge clk);
      #1;
      check("reset_out", bus.out, 32'h0000_0000);

      // Release; the first edge loads the operands present at that edge.
      @(negedge clk);
      bus.A = 16'd1;
      bus.B = 16'd1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("first_after_release", bus.out, 32'h0000_0001);

      apply("zero_a",     16'h0000, 16'h1234, 32'h0000_0000);
      apply("one_one",    16'h0001, 16'h0001, 32'h0000_0001);
      apply("neg1_one",   16'hFFFF, 16'h0001, 32'hFFFF_FFFF);
      apply("three_3",    16'h0003, 16'h0003, 32'h0000_FFFD);
      apply("two_3",      16'h0002, 16'h0003, 32'h0000_FFFE);
      apply("min_min",    16'h8000, 16'h8000, 32'h4000_0000);
      apply("x100_x100",  16'h0100, 16'h0100, 32'h0001_0000);
      apply("five_neg1",  16'h0005, 16'hFFFF, 32'hFFFF_FFFB);

      // Back-to-back random operands, one pair per cycle.
      for (int n = 0; n < 24; n++) begin
         ra = 16'($urandom_range(0, 65535));
         rb = 16'($urandom_range(0, 65535));
         @(negedge clk);
         bus.A = ra;
         bus.B = rb;
         @(posedge clk);
         #1;
         exact = 32'($signed(ra) * $signed(rb));
         check($sformatf("rnd%0d_a%04h_b%04h", n, ra, rb), bus.out, model(ra, rb));
         check($sformatf("rnd%0d_upper", n), {16'd0, bus.out[31:16]}, {16'd0, exact[31:16]});
      end

      // Reset between edges while a new result is pending.
      apply("pre_reset", 16'h0003, 16'h0005, model(16'h0003, 16'h0005));
      @(negedge clk);
      bus.A = 16'h0007;
      bus.B = 16'h0009;
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset", bus.out, 32'h0000_0000);
      @(posedge clk);
      #1;
      check("held_in_reset", bus.out, 32'h0000_0000);
      @(negedge clk);
      bus.A = 16'h8000;
      bus.B = 16'h8000;
      rst_n = 1'b1;
      #1;
      check("released_no_pending", bus.out, 32'h0000_0000);
      @(posedge clk);
      #1;
      check("first_after_mid_reset", bus.out, 32'h4000_0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
